// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=7 (133/171 octal) convolutional encoder with 802.11a puncturing.
// Puncturing (rates 2/3, 3/4) is compiled only when CONV_ENC_PUNCTURE_EN is defined.
module conv_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_first,
    input  logic       in_last,
    input  logic [1:0] rate,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);
    logic [5:0] sr_q, sr_d, sr_cur;
    logic [1:0] hold_q, hold_d, cnt_q, cnt_d, ld;
    logic       last_q, last_d, acc, emit, a, b, two;

    assign in_ready  = (cnt_q == 2'd0) || (cnt_q == 2'd1 && out_ready);
    assign acc       = in_valid && in_ready;
    assign out_valid = cnt_q != 2'd0;
    assign emit      = out_valid && out_ready;
    assign out_bit   = hold_q[0];
    assign out_last  = last_q && cnt_q == 2'd1;
    // A frame start encodes against an all-zero history.
    assign sr_cur    = in_first ? 6'd0 : sr_q;
    assign a         = in_bit ^ sr_cur[1] ^ sr_cur[2] ^ sr_cur[4] ^ sr_cur[5];
    assign b         = in_bit ^ sr_cur[0] ^ sr_cur[1] ^ sr_cur[2] ^ sr_cur[5];

`ifdef CONV_ENC_PUNCTURE_EN
    logic [1:0] rate_q, rate_d, rate_cur, ph_q, ph_d, ph_cur, ph_nx;
    assign rate_cur = in_first ? (rate == 2'b11 ? 2'b00 : rate) : rate_q;
    assign ph_cur   = in_first ? 2'd0 : ph_q;
    assign two      = ph_cur == 2'd0;
    assign ld       = two ? {b, a} : {1'b0, ph_cur == 2'd1 ? a : b};
    assign ph_nx    = rate_cur == 2'b10 ? (ph_cur == 2'd2 ? 2'd0 : ph_cur + 2'd1) :
                      rate_cur == 2'b01 ? (ph_cur == 2'd1 ? 2'd0 : 2'd1) : 2'd0;
`else
    logic unused_rate;
    assign unused_rate = ^rate;
    assign two         = 1'b1;
    assign ld          = {b, a};
`endif

    always_comb begin
        sr_d   = sr_q;
        hold_d = hold_q;
        cnt_d  = cnt_q;
        last_d = last_q;
`ifdef CONV_ENC_PUNCTURE_EN
        rate_d = rate_q;
        ph_d   = ph_q;
`endif
        // An accept only happens once the buffer is empty or draining its last bit.
        if (acc) begin
            sr_d   = {sr_cur[4:0], in_bit};
            hold_d = ld;
            cnt_d  = two ? 2'd2 : 2'd1;
            last_d = in_last;
`ifdef CONV_ENC_PUNCTURE_EN
            rate_d = rate_cur;
            ph_d   = ph_nx;
`endif
        end else if (emit) begin
            hold_d = {1'b0, hold_q[1]};
            cnt_d  = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            hold_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
`ifdef CONV_ENC_PUNCTURE_EN
            rate_q <= '0;
            ph_q   <= '0;
`endif
        end else begin
            sr_q   <= sr_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
`ifdef CONV_ENC_PUNCTURE_EN
            rate_q <= rate_d;
            ph_q   <= ph_d;
`endif
        end
    end
endmodule
